// File: rtl/reflet_uart_loader.sv
// UART (8N1) boot loader: receives a framed program image, writes it word by word
// into instruction RAM and releases the CPU once the checksum has been verified.
module reflet_uart_loader #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600,
  parameter int unsigned wordsize  = 16,
  parameter int unsigned addr_size = 9,
  parameter logic [7:0]  magic     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [addr_size-1:0] mem_addr,
  output logic [wordsize-1:0]  mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_hold,
  output logic                 loaded,
  output logic                 error
);

  localparam int unsigned CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BPW          = wordsize / 8;
  localparam int unsigned BC_W         = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WC_W         = (addr_size + 1 > 16) ? addr_size + 1 : 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  // Receiver: 2-flop synchronizer (rx_s3 only serves falling-edge detection)
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2 && rx_s3) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            rx_byte <= {rx_s2, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt    <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  state_t          state;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [WC_W-1:0] word_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      sum;
  logic [wordsize-1:0] word_reg;
  logic [wordsize-1:0] word_nxt;
  logic [15:0]     len_full;
  logic            word_done;
  logic            last_word;

  always_comb begin
    word_nxt = word_reg;
    word_nxt[8*int'(byte_cnt) +: 8] = rx_byte;
  end

  assign len_full  = {rx_byte, len_lo};
  assign word_done = (byte_cnt == BC_W'(BPW - 1));
  assign last_word = (word_cnt + WC_W'(1) == WC_W'(len));

  // Frame parser; outputs are registered and follow the consumed byte by one clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      cpu_hold     <= 1'b1;
      loaded       <= 1'b0;
      error        <= 1'b0;
      len_lo       <= '0;
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      sum          <= '0;
      word_reg     <= '0;
    end else begin
      mem_write_en <= 1'b0;
      if (frame_err && state != S_IDLE && state != S_DONE) begin
        state    <= S_ERROR;
        error    <= 1'b1;
        cpu_hold <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (rx_byte == magic) begin
              state <= S_LEN_LO;
              error <= 1'b0;
            end
          end
          S_LEN_LO: begin
            len_lo <= rx_byte;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len      <= len_full;
            word_cnt <= '0;
            byte_cnt <= '0;
            sum      <= '0;
            if (32'(len_full) > (32'd1 << addr_size)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            sum      <= sum + rx_byte;
            word_reg <= word_nxt;
            if (word_done) begin
              byte_cnt     <= '0;
              mem_write_en <= 1'b1;
              mem_addr     <= word_cnt[addr_size-1:0];
              mem_data     <= word_nxt;
              word_cnt     <= word_cnt + WC_W'(1);
              if (last_word) state <= S_CHECK;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
          S_CHECK: begin
            if (rx_byte == sum) begin
              state    <= S_DONE;
              loaded   <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reflet_uart_loader.sv
// Self-checking bench for reflet_uart_loader: frames are built from word lists,
// serialised bit by bit, and the captured RAM writes/status compared to the model.
module tb_reflet_uart_loader;

  localparam int unsigned CLK_FREQ = 600000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned WS       = 16;
  localparam int unsigned AS       = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [AS-1:0] mem_addr;
  logic [WS-1:0] mem_data;
  logic          mem_write_en;
  logic          cpu_hold;
  logic          loaded;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [AS-1:0] wr_addr_q[$];
  logic [WS-1:0] wr_data_q[$];
  logic [WS-1:0] exp_words[$];
  logic [7:0]    frame_q[$];

  always #5 clk = ~clk;

  reflet_uart_loader #(
    .clk_freq(CLK_FREQ), .baud_rate(BAUD), .wordsize(WS), .addr_size(AS), .magic(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write_en(mem_write_en), .cpu_hold(cpu_hold), .loaded(loaded), .error(error)
  );

  // Each sampled high cycle of the strobe is one recorded write
  always @(negedge clk) begin
    if (mem_write_en) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    repeat (10) @(negedge clk);
  endtask

  // Frame = magic, length, little-endian words, then checksum (+ deliberate offset)
  task automatic build_frame(input logic [7:0] chk_delta);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = exp_words.size();
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    foreach (exp_words[i]) begin
      frame_q.push_back(exp_words[i][7:0]);
      frame_q.push_back(exp_words[i][15:8]);
      s = s + exp_words[i][7:0] + exp_words[i][15:8];
    end
    frame_q.push_back(s + chk_delta);
  endtask

  function automatic int bad_writes();
    int n = 0;
    if (wr_data_q.size() != exp_words.size()) return -1;
    foreach (exp_words[i])
      if (wr_addr_q[i] !== AS'(i) || wr_data_q[i] !== exp_words[i]) n++;
    return n;
  endfunction

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_reset();
    rx = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_writes();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", mem_write_en); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %0b want 1", cpu_hold); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %0b want 0", loaded); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", error); end
    checks++; if (mem_addr !== '0 || mem_data !== '0) begin errors++; $display("FAIL reset_bus got %h/%h want 0/0", mem_addr, mem_data); end
  endtask

  task automatic test_basic();
    do_reset();
    exp_words.delete();
    exp_words.push_back(16'h1234);
    exp_words.push_back(16'h5678);
    build_frame(8'h00);
    checks++; if (frame_q[7] !== 8'h14) begin errors++; $display("FAIL basic_chk_byte got %h want 14", frame_q[7]); end
    send_frame();
    checks++; if (bad_writes() != 0) begin errors++; $display("FAIL basic_writes got %0d writes want 2 exact", wr_data_q.size()); end
    checks++; if (loaded !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL basic_status got l=%0b h=%0b e=%0b want 1 0 0", loaded, cpu_hold, error); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    build_frame(8'h01);
    send_frame();
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || loaded !== 1'b0) begin
      errors++; $display("FAIL badchk_status got e=%0b h=%0b l=%0b want 1 1 0", error, cpu_hold, loaded); end
    checks++; if (bad_writes() != 0) begin errors++; $display("FAIL badchk_writes got %0d want 2", wr_data_q.size()); end
    clear_writes();
    build_frame(8'h00);
    send_frame();
    checks++; if (error !== 1'b0 || loaded !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL retry_status got e=%0b l=%0b h=%0b want 0 1 0", error, loaded, cpu_hold); end
  endtask

  task automatic test_leading_and_glitch();
    logic [7:0] junk[3];
    junk = '{8'h00, 8'hFF, 8'h3C};
    do_reset();
    foreach (junk[i]) send_byte(junk[i], 1'b1);
    send_frame();
    checks++; if (bad_writes() != 0 || loaded !== 1'b1) begin
      errors++; $display("FAIL leading_bytes got %0d writes l=%0b want 2 1", wr_data_q.size(), loaded); end
    // A glitch read as a byte would corrupt the length and reject the frame
    do_reset();
    send_byte(frame_q[0], 1'b1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (bad_writes() != 0 || loaded !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL glitch got %0d writes l=%0b e=%0b want 2 1 0", wr_data_q.size(), loaded, error); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int nw;
      logic bad;
      logic [7:0] delta;
      nw = $urandom_range(1, 6);
      bad = ($urandom_range(0, 1) == 0);
      delta = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      exp_words.delete();
      for (int i = 0; i < nw; i++) exp_words.push_back(WS'($urandom));
      do_reset();
      build_frame(delta);
      send_frame();
      checks++; if (bad_writes() != 0) begin errors++; $display("FAIL rand%0d_writes got %0d want %0d", t, wr_data_q.size(), nw); end
      checks++; if (loaded !== !bad || error !== bad || cpu_hold !== bad) begin
        errors++; $display("FAIL rand%0d_status got l=%0b e=%0b h=%0b want %0b %0b %0b", t, loaded, error, cpu_hold, !bad, bad, bad); end
    end
  endtask

  task automatic test_length_limits();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (error !== 1'b1 || wr_data_q.size() != 0) begin
      errors++; $display("FAIL len513 got e=%0b writes=%0d want 1 0", error, wr_data_q.size()); end
    exp_words.delete();
    for (int i = 0; i < 512; i++) exp_words.push_back(WS'($urandom));
    build_frame(8'h00);
    send_frame();
    checks++; if (bad_writes() != 0) begin errors++; $display("FAIL len512_writes got %0d want 512 exact", wr_data_q.size()); end
    checks++; if (wr_addr_q.size() != 512 || wr_addr_q[511] !== 9'h1FF || loaded !== 1'b1) begin
      errors++; $display("FAIL len512_last got n=%0d l=%0b want 512 addr 1ff l=1", wr_addr_q.size(), loaded); end
    do_reset();
    exp_words.delete();
    build_frame(8'h00);
    send_frame();
    checks++; if (loaded !== 1'b1 || wr_data_q.size() != 0) begin
      errors++; $display("FAIL len0 got l=%0b writes=%0d want 1 0", loaded, wr_data_q.size()); end
  endtask

  task automatic test_frame_error();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_bit(1'b1);
    repeat (10) @(negedge clk);
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || loaded !== 1'b0) begin
      errors++; $display("FAIL stop0 got e=%0b h=%0b l=%0b want 1 1 0", error, cpu_hold, loaded); end
    checks++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 16'h2211) begin
      errors++; $display("FAIL stop0_writes got %0d want 1 of 2211", wr_data_q.size()); end
  endtask

  task automatic test_reset_in_data();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1 || mem_write_en !== 1'b0) begin
      errors++; $display("FAIL rst_data_hold got h=%0b we=%0b want 1 0", cpu_hold, mem_write_en); end
    @(negedge clk);
    reset = 1'b0;
    clear_writes();
    repeat (30 * CPB) @(negedge clk);
    checks++; if (wr_data_q.size() != 0 || cpu_hold !== 1'b1 || loaded !== 1'b0) begin
      errors++; $display("FAIL rst_data_quiet got writes=%0d h=%0b l=%0b want 0 1 0", wr_data_q.size(), cpu_hold, loaded); end
    exp_words.delete();
    exp_words.push_back(16'hBEEF);
    build_frame(8'h00);
    send_frame();
    checks++; if (bad_writes() != 0 || loaded !== 1'b1) begin
      errors++; $display("FAIL rst_data_reload got writes=%0d l=%0b want 1 1", wr_data_q.size(), loaded); end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_checksum();
    test_leading_and_glitch();
    test_random();
    test_length_limits();
    test_frame_error();
    test_reset_in_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
